// File: rtl/riscv_boot_loader.sv
// -----------------------------------------------------------------------------
// riscv_boot_loader
//
// Boot stage placed in front of the CPU top. While the core is held in reset
// it accepts a byte-serial program image on a valid/ready stream:
//   [N lo][N hi] then 4*N data bytes, each word least-significant byte first.
// It packs the bytes into 32-bit little-endian words and writes them to
// instruction memory at word addresses 0..N-1. After the last write and a
// RELEASE_DLY settle delay, the core reset is released.
//
// Optional feature macro: RISCV_BOOT_CHECKSUM_EN
//   When defined, one extra byte follows the data: the XOR of all 4*N data
//   bytes. A match proceeds to release; a mismatch latches boot_err.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    byte stream valid
//   in_data     byte stream data
//   in_ready    byte accepted when in_valid && in_ready at the rising edge
//   imem_we     instruction-memory write strobe, one cycle per word
//   imem_addr   word address of the write
//   imem_wdata  word to write
//   core_rst_n  active-low reset to the CPU core
//   boot_done   image loaded and core released
//   boot_err    image rejected; core held in reset
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_LEN0 | waiting for low byte of word count N
// S_LEN1 | waiting for high byte of N; range-checked against DEPTH
// S_DATA | packing data bytes, one imem write per 4 bytes
// S_CSUM | waiting for the checksum byte (checksum build only)
// S_WAIT | settle down-counter running before core release
// S_RUN  | core released; terminal until rst_n
// S_ERR  | image rejected; terminal until rst_n
// -----------------------------------------------------------------------------
module riscv_boot_loader #(
  parameter int ADDR_W      = 10,
  parameter int DEPTH       = 1024,
  parameter int RELEASE_DLY = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              boot_done,
  output logic              boot_err
);

  localparam int DLY_W = $clog2(RELEASE_DLY + 1);

`ifdef RISCV_BOOT_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_LEN0, S_LEN1, S_DATA, S_WAIT, S_RUN, S_ERR, S_CSUM
  } state_t;
`else
  typedef enum logic [2:0] {
    S_LEN0, S_LEN1, S_DATA, S_WAIT, S_RUN, S_ERR
  } state_t;
`endif

  state_t              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [23:0]         asm_q, asm_d;
  logic [ADDR_W-1:0]   word_cnt_q, word_cnt_d;
  logic [DLY_W-1:0]    dly_q, dly_d;
  logic                imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
  logic [31:0]         imem_wdata_q, imem_wdata_d;
  logic                core_rst_n_q, core_rst_n_d;
  logic                boot_done_q, boot_done_d;
  logic                boot_err_q, boot_err_d;
`ifdef RISCV_BOOT_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  logic                accept;
  logic [15:0]         n_full;
  logic                last_word;

  assign accept    = in_valid && in_ready;
  assign n_full    = {in_data, len_q[7:0]};
  assign last_word = (32'(word_cnt_q) == (32'(len_q) - 32'd1));

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    byte_cnt_d   = byte_cnt_q;
    asm_d        = asm_q;
    word_cnt_d   = word_cnt_q;
    dly_d        = dly_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    in_ready     = 1'b0;
`ifdef RISCV_BOOT_CHECKSUM_EN
    csum_d       = csum_q;
`endif

    case (state_q)
      S_LEN0: begin
        in_ready = 1'b1;
        if (accept) begin
          len_d[7:0] = in_data;
          state_d    = S_LEN1;
        end
      end

      S_LEN1: begin
        in_ready = 1'b1;
        if (accept) begin
          len_d[15:8] = in_data;
          if ({16'd0, n_full} > 32'(DEPTH)) begin
            state_d = S_ERR;
          end else if (n_full == 16'd0) begin
`ifdef RISCV_BOOT_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_WAIT;
`endif
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        // Writes are a side effect of the 4th byte; input is never stalled.
        in_ready = 1'b1;
        if (accept) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef RISCV_BOOT_CHECKSUM_EN
          csum_d     = csum_q ^ in_data;
`endif
          case (byte_cnt_q)
            2'd0: asm_d[7:0]   = in_data;
            2'd1: asm_d[15:8]  = in_data;
            2'd2: asm_d[23:16] = in_data;
            default: begin
              imem_we_d    = 1'b1;
              imem_addr_d  = word_cnt_q;
              imem_wdata_d = {in_data, asm_q};
              word_cnt_d   = word_cnt_q + 1'b1;
              if (last_word) begin
`ifdef RISCV_BOOT_CHECKSUM_EN
                state_d = S_CSUM;
`else
                state_d = S_WAIT;
`endif
              end
            end
          endcase
        end
      end

`ifdef RISCV_BOOT_CHECKSUM_EN
      S_CSUM: begin
        in_ready = 1'b1;
        if (accept) begin
          state_d = (in_data == csum_q) ? S_WAIT : S_ERR;
        end
      end
`endif

      S_WAIT: begin
        // Counter was loaded on entry; release on the edge it reaches zero.
        dly_d = dly_q - DLY_W'(1);
        if (dly_q <= DLY_W'(1)) begin
          state_d = S_RUN;
        end
      end

      default: ;  // S_RUN and S_ERR are terminal
    endcase

    if (state_d == S_WAIT && state_q != S_WAIT) begin
      dly_d = DLY_W'(RELEASE_DLY);
    end

    // Status outputs are registered from the next state so they change
    // together with the state register.
    core_rst_n_d = (state_d == S_RUN);
    boot_done_d  = (state_d == S_RUN);
    boot_err_d   = (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_LEN0;
      len_q        <= '0;
      byte_cnt_q   <= '0;
      asm_q        <= '0;
      word_cnt_q   <= '0;
      dly_q        <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_rst_n_q <= 1'b0;
      boot_done_q  <= 1'b0;
      boot_err_q   <= 1'b0;
`ifdef RISCV_BOOT_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      byte_cnt_q   <= byte_cnt_d;
      asm_q        <= asm_d;
      word_cnt_q   <= word_cnt_d;
      dly_q        <= dly_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      core_rst_n_q <= core_rst_n_d;
      boot_done_q  <= boot_done_d;
      boot_err_q   <= boot_err_d;
`ifdef RISCV_BOOT_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_rst_n = core_rst_n_q;
  assign boot_done  = boot_done_q;
  assign boot_err   = boot_err_q;

endmodule
